// File: rtl/ascii_dec_parser_if.sv
// ascii_dec_parser_if: byte-in / number-out stream bundle for ascii_dec_parser.
// The slave modport is the parser's view; master is the byte source and
// result consumer's view.
interface ascii_dec_parser_if #(
  parameter int VALUE_W = 16,
  parameter int CNT_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_char;
  logic               out_valid;
  logic               out_ready;
  logic [VALUE_W-1:0] out_value;
  logic [CNT_W-1:0]   out_ndigits;
  logic               out_err;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_value, out_ndigits, out_err
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_value, out_ndigits, out_err
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser: streaming ASCII decimal text to binary converter.
// Runs of '0'..'9' accumulate into an unsigned value; the first non-digit
// after a run terminates it and the result is held until the consumer takes it.
// Optional build macro ASCII_DEC_PARSER_SIGN_EN: a leading '-' makes the
// number negative, with two's complement output and signed saturation.
module ascii_dec_parser #(
  parameter int VALUE_W = 16,
  parameter int CNT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  ascii_dec_parser_if.slave bus
);

  // Extra 4 bits hold acc*10+9 without wrapping, so overflow is a plain compare.
  localparam int EXT_W = VALUE_W + 4;
  localparam logic [EXT_W-1:0] TEN = EXT_W'(10);
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_9     = 8'h39;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  // Magnitude ceilings: 2^(W-1)-1 for positive, 2^(W-1) for negative numbers.
  localparam logic [EXT_W-1:0] LIM_POS = EXT_W'({(VALUE_W-1){1'b1}});
  localparam logic [EXT_W-1:0] LIM_NEG = LIM_POS + EXT_W'(1);
`else
  localparam logic [EXT_W-1:0] LIM_UNS = EXT_W'({VALUE_W{1'b1}});
`endif

`ifdef ASCII_DEC_PARSER_SIGN_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD, S_SIGN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;

  logic [VALUE_W-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [VALUE_W-1:0] r_out_value;
  logic [CNT_W-1:0]   r_out_ndigits;
  logic               r_out_err;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  logic               r_neg;
  logic               w_is_minus;
`endif

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_is_digit;
  logic [3:0]         w_digit;
  logic               w_in_num;
  logic [EXT_W-1:0]   w_base;
  logic [EXT_W-1:0]   w_prod;
  logic [EXT_W-1:0]   w_limit;
  logic               w_over;
  logic [VALUE_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Character classification and handshake qualification.
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_is_digit = (bus.in_char >= CHAR_0) && (bus.in_char <= CHAR_9);
  // For '0'..'9' the low nibble already equals in_char - 8'h30.
  assign w_digit    = bus.in_char[3:0];
`ifdef ASCII_DEC_PARSER_SIGN_EN
  assign w_is_minus = (bus.in_char == CHAR_MINUS);
`endif

  // Accumulator arithmetic: a first digit starts from zero, later digits
  // extend the running value; an earlier overflow stays sticky.
  assign w_in_num  = (r_state == S_ACCUM);
  assign w_base    = w_in_num ? EXT_W'(r_acc) : '0;
  assign w_prod    = w_base * TEN + EXT_W'(w_digit);
`ifdef ASCII_DEC_PARSER_SIGN_EN
  assign w_limit   = r_neg ? LIM_NEG : LIM_POS;
`else
  assign w_limit   = LIM_UNS;
`endif
  assign w_over    = (w_prod > w_limit) || (w_in_num && r_err);
  assign w_acc_nxt = w_over ? w_limit[VALUE_W-1:0] : w_prod[VALUE_W-1:0];
  assign w_cnt_nxt = !w_in_num ? CNT_W'(1)
                   : (&r_cnt)  ? r_cnt
                   :             r_cnt + CNT_W'(1);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode, driven only by accepted bytes and the output handshake.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_digit) w_state_nxt = S_ACCUM;
`ifdef ASCII_DEC_PARSER_SIGN_EN
        else if (w_accept && w_is_minus) w_state_nxt = S_SIGN;
`endif
      end
`ifdef ASCII_DEC_PARSER_SIGN_EN
      S_SIGN: begin
        if (w_accept) w_state_nxt = w_is_digit ? S_ACCUM : S_IDLE;
      end
`endif
      S_ACCUM: begin
        if (w_accept && !w_is_digit) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state alone (in_ready never looks at in_valid).
  always_comb begin
    w_in_ready  = (r_state != S_HOLD);
    w_out_valid = (r_state == S_HOLD);
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_value   = r_out_value;
  assign bus.out_ndigits = r_out_ndigits;
  assign bus.out_err     = r_out_err;

  // Running value, digit count and overflow flag for the number in progress.
  // NOTE: the datapath is reset too, so a reset mid-number leaves no stale
  // partial value visible anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept && w_is_digit) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_over;
    end
  end

  // Result registers, captured when the terminator is consumed; they keep
  // their contents after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_value   <= '0;
      r_out_ndigits <= '0;
      r_out_err     <= 1'b0;
    end else if (w_in_num && w_accept && !w_is_digit) begin
`ifdef ASCII_DEC_PARSER_SIGN_EN
      r_out_value   <= r_neg ? (~r_acc + VALUE_W'(1)) : r_acc;
`else
      r_out_value   <= r_acc;
`endif
      r_out_ndigits <= r_cnt;
      r_out_err     <= r_err;
    end
  end

`ifdef ASCII_DEC_PARSER_SIGN_EN
  // Sign flag: set by '-' in IDLE, dropped whenever the parser returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           r_neg <= 1'b0;
    else if (w_state_nxt == S_IDLE)                    r_neg <= 1'b0;
    else if (r_state == S_IDLE && w_accept && w_is_minus) r_neg <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Self-checking bench for ascii_dec_parser: directed scenarios with constant
// expectations plus randomized streams checked against a text-level model.
`timescale 1ns/1ps
module tb_ascii_dec_parser;
  localparam int VALUE_W = 16;
  localparam int CNT_W   = 4;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef logic [7:0] char_t;
  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [CNT_W-1:0]   nd;
    logic               err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ascii_dec_parser_if #(.VALUE_W(VALUE_W), .CNT_W(CNT_W)) bus ();

  ascii_dec_parser #(.VALUE_W(VALUE_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  char_t stim_q[$];
  res_t  exp_q[$];
  res_t  got_q[$];
  int    acc_cyc[$];
  int    out_rise;

  function automatic void load(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(char_t'(s[i]));
  endfunction

  function automatic res_t got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '0;
  endfunction

  // Largest magnitude a number may reach before it saturates.
  function automatic longint mag_limit(input bit neg);
    if (SIGNED_BUILD) return neg ? (longint'(1) << (VALUE_W-1)) : (longint'(1) << (VALUE_W-1)) - 1;
    return (longint'(1) << VALUE_W) - 1;
  endfunction

  // Reference model: scan the text, emit one result per terminated digit run.
  function automatic void build_model();
    bit     in_num = 0;
    bit     neg    = 0;
    bit     pend   = 0;
    bit     err    = 0;
    longint mag    = 0;
    int     nd     = 0;
    char_t  c;
    res_t   r;
    exp_q.delete();
    foreach (stim_q[i]) begin
      c = stim_q[i];
      if (c >= "0" && c <= "9") begin
        if (!in_num) begin
          in_num = 1; mag = 0; nd = 0; err = 0; neg = pend;
        end
        pend = 0;
        mag  = mag * 10 + longint'(c - 8'h30);
        nd++;
        if (err || mag > mag_limit(neg)) begin
          err = 1; mag = mag_limit(neg);
        end
      end else if (in_num) begin
        r.value = VALUE_W'(neg ? -mag : mag);
        r.nd    = CNT_W'((nd > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : nd);
        r.err   = err;
        exp_q.push_back(r);
        in_num = 0; neg = 0;
      end else begin
        pend = SIGNED_BUILD && !pend && (c == "-");
      end
    end
  endfunction

  // Drive stim_q through the parser with random gaps/backpressure; the first
  // `stall` cycles of out_valid see out_ready low. Collects delivered results.
  task automatic run_stream(input int valid_pct, input int ready_pct, input int stall);
    int   idx = 0;
    int   cyc = 0;
    int   budget;
    int   stall_left = stall;
    bit   prev_hold = 0;
    res_t prev_r = '0;
    res_t cur_r;
    build_model();
    budget   = 40 * stim_q.size() + 100;
    out_rise = -1;
    got_q.delete();
    acc_cyc.delete();
    while ((idx < stim_q.size() || got_q.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      if (idx < stim_q.size()) begin
        bus.in_char  = stim_q[idx];
        bus.in_valid = (int'($urandom_range(99)) < valid_pct);
      end else begin
        bus.in_char  = 8'h00;
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = (int'($urandom_range(99)) < ready_pct);
      end
      #1;
      cur_r = '{bus.out_value, bus.out_ndigits, bus.out_err};
      if (bus.out_valid) begin
        if (out_rise < 0) out_rise = cyc;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL in_ready_in_hold: got %b want 0 (cycle %0d)", bus.in_ready, cyc);
        else n_pass++;
      end
      if (prev_hold) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || cur_r !== prev_r)
          $display("FAIL hold_stable: got valid=%b %h want valid=1 %h", bus.out_valid, cur_r, prev_r);
        else n_pass++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_r    = cur_r;
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(cur_r);
      cyc++;
    end
    n_checks++;
    if (idx < stim_q.size() || got_q.size() < exp_q.size())
      $display("FAIL stream_timeout: got %0d bytes %0d results want %0d bytes %0d results",
               idx, got_q.size(), stim_q.size(), exp_q.size());
    else n_pass++;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_value, bus.out_ndigits, bus.out_err} !==
        {1'b1, 1'b0, {VALUE_W{1'b0}}, {CNT_W{1'b0}}, 1'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b val=%h nd=%0d err=%b want rdy=1 vld=0 val=0 nd=0 err=0",
               bus.in_ready, bus.out_valid, bus.out_value, bus.out_ndigits, bus.out_err);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    res_t r;
    load("123\n");
    run_stream(100, 100, 0);
    r = got_at(0);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL basic_count: got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (r !== res_t'({16'd123, 4'd3, 1'b0})) $display("FAIL basic_result: got %h want val=123 nd=3 err=0", r);
    else n_pass++;
    n_checks++;
    if (acc_cyc.size() != 4 || out_rise != acc_cyc[3] + 1)
      $display("FAIL basic_latency: got out_valid at cycle %0d want one cycle after terminator", out_rise);
    else n_pass++;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_release: got out_valid=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [VALUE_W-1:0] sat = SIGNED_BUILD ? 16'h7FFF : 16'hFFFF;
    load("65536,9,65535,");
    run_stream(100, 100, 0);
    n_checks++;
    if (got_q.size() !== 3) $display("FAIL ovf_count: got %0d want 3", got_q.size()); else n_pass++;
    n_checks++;
    if (got_at(0) !== res_t'({sat, 4'd5, 1'b1})) $display("FAIL ovf_sat: got %h want val=%h nd=5 err=1", got_at(0), sat);
    else n_pass++;
    n_checks++;
    if (got_at(1) !== res_t'({16'd9, 4'd1, 1'b0})) $display("FAIL ovf_err_clear: got %h want val=9 nd=1 err=0", got_at(1));
    else n_pass++;
    n_checks++;
    if (got_at(2) !== res_t'({sat, 4'd5, SIGNED_BUILD})) $display("FAIL ovf_boundary: got %h want val=%h err=%b", got_at(2), sat, SIGNED_BUILD);
    else n_pass++;
  endtask

  task automatic test_junk();
    load("ab 7 ");
    run_stream(100, 100, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 1 || got_at(0) !== res_t'({16'd7, 4'd1, 1'b0}))
      $display("FAIL junk: got %0d results first %h want 1 result val=7 nd=1", got_q.size(), got_at(0));
    else n_pass++;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL junk_extra: got out_valid=%b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    load("12;34;");
    run_stream(100, 100, 5);
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size()); else n_pass++;
    n_checks++;
    if (got_at(0) !== res_t'({16'd12, 4'd2, 1'b0}) || got_at(1) !== res_t'({16'd34, 4'd2, 1'b0}))
      $display("FAIL b2b_values: got %h %h want 12/2 and 34/2", got_at(0), got_at(1));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    load("45");
    run_stream(100, 100, 0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL async_reset: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    else n_pass++;
    #5 rst = 1'b0;
    load("6.");
    run_stream(100, 100, 0);
    n_checks++;
    if (got_q.size() !== 1 || got_at(0) !== res_t'({16'd6, 4'd1, 1'b0}))
      $display("FAIL reset_mid: got %0d results first %h want 1 result val=6 nd=1", got_q.size(), got_at(0));
    else n_pass++;
  endtask

  task automatic test_leading_zeros();
    load("007;000000000000000012;");
    run_stream(100, 100, 0);
    n_checks++;
    if (got_at(0) !== res_t'({16'd7, 4'd3, 1'b0})) $display("FAIL lead_zero: got %h want val=7 nd=3", got_at(0));
    else n_pass++;
    n_checks++;
    if (got_at(1) !== res_t'({16'd12, 4'd15, 1'b0})) $display("FAIL nd_saturate: got %h want val=12 nd=15", got_at(1));
    else n_pass++;
  endtask

`ifdef ASCII_DEC_PARSER_SIGN_EN
  task automatic test_sign();
    load("-42;-32768;32768;-32769;-x");
    run_stream(100, 100, 0);
    n_checks++;
    if (got_q.size() !== 4) $display("FAIL sign_count: got %0d want 4", got_q.size()); else n_pass++;
    n_checks++;
    if (got_at(0) !== res_t'({16'hFFD6, 4'd2, 1'b0})) $display("FAIL sign_neg42: got %h want FFD6/2/0", got_at(0)); else n_pass++;
    n_checks++;
    if (got_at(1) !== res_t'({16'h8000, 4'd5, 1'b0})) $display("FAIL sign_min: got %h want 8000/5/0", got_at(1)); else n_pass++;
    n_checks++;
    if (got_at(2) !== res_t'({16'h7FFF, 4'd5, 1'b1})) $display("FAIL sign_pos_sat: got %h want 7FFF/5/1", got_at(2)); else n_pass++;
    n_checks++;
    if (got_at(3) !== res_t'({16'h8000, 4'd5, 1'b1})) $display("FAIL sign_neg_sat: got %h want 8000/5/1", got_at(3)); else n_pass++;
  endtask
`endif

  task automatic test_random();
    string pool = " ,;.\nabZ-";
    for (int round = 0; round < 25; round++) begin
      stim_q.delete();
      for (int t = 0; t < int'($urandom_range(6, 1)); t++) begin
        for (int j = 0; j < int'($urandom_range(2)); j++)
          stim_q.push_back(char_t'(pool[$urandom_range(pool.len() - 1)]));
        for (int j = 0; j < int'($urandom_range(6, 1)); j++)
          stim_q.push_back(char_t'(8'h30 + $urandom_range(9)));
        stim_q.push_back(char_t'(pool[$urandom_range(pool.len() - 1)]));
      end
      run_stream(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), int'($urandom_range(3)));
      n_checks++;
      if (got_q.size() !== exp_q.size())
        $display("FAIL rand_count: round %0d got %0d want %0d", round, got_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[k]) begin
        n_checks++;
        if (got_at(k) !== exp_q[k])
          $display("FAIL rand_result: round %0d #%0d got %h want %h", round, k, got_at(k), exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_junk();
    test_back_to_back();
    test_reset_mid();
    test_leading_zeros();
`ifdef ASCII_DEC_PARSER_SIGN_EN
    test_sign();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
